// File: rtl/decode_stage.sv
// decode_stage: instruction-decode pipeline stage.
// Splits the instruction into fields and reads two operands from a 32-entry
// register file. All results are registered, so they appear one cycle later.
// A writeback port updates the register file, and register 0 always reads as zero.
// Optional feature: define DECODE_WB_BYPASS_EN to forward same-edge writeback
// data to a matching source operand. This is write-through forwarding.
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instruction,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [5:0]        opcode,
    output logic [4:0]        dst,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2,
    output logic [9:0]        offsetlo
);

    logic [4:0]        src1_idx;
    logic [4:0]        src2_idx;
    logic [DATA_W-1:0] rf_view [REG_N];
    logic [DATA_W-1:0] src1_next;
    logic [DATA_W-1:0] src2_next;

    logic [5:0]        opcode_reg;
    logic [4:0]        dst_reg;
    logic [DATA_W-1:0] src1_reg;
    logic [DATA_W-1:0] src2_reg;
    logic [9:0]        offsetlo_reg;

    assign src1_idx = instruction[19:15];
    assign src2_idx = instruction[14:10];

    // Register file. Entry 0 is a constant zero, so writes to index 0 are
    // discarded without needing an explicit check. Each of the other entries
    // is its own cleared-on-reset register. This lets the reset clear all
    // entries at once, which a RAM macro could not do.
    genvar gi;
    generate
        for (gi = 0; gi < REG_N; gi++) begin : g_rf
            if (gi == 0) begin : g_zero
                assign rf_view[gi] = '0;
            end else begin : g_entry
                logic [DATA_W-1:0] entry_reg;

                // Capture writeback data when this entry is addressed
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)
                        entry_reg <= '0;
                    else if (wb_en && (wb_addr == 5'(gi)))
                        entry_reg <= wb_data;
                end

                assign rf_view[gi] = entry_reg;
            end
        end
    endgenerate

`ifdef DECODE_WB_BYPASS_EN
    // A write landing on the same edge as a read of that index is forwarded.
    // Each source is checked on its own. Index 0 is never forwarded.
    assign src1_next = (wb_en && (wb_addr != 5'd0) && (wb_addr == src1_idx))
                       ? wb_data : rf_view[src1_idx];
    assign src2_next = (wb_en && (wb_addr != 5'd0) && (wb_addr == src2_idx))
                       ? wb_data : rf_view[src2_idx];
`else
    // Without forwarding, a same-edge read sees the old contents. The new
    // value becomes visible from the next edge.
    assign src1_next = rf_view[src1_idx];
    assign src2_next = rf_view[src2_idx];
`endif

    // Pipeline output registers. Bit 31 of the instruction is reserved and is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_reg   <= '0;
            dst_reg      <= '0;
            src1_reg     <= '0;
            src2_reg     <= '0;
            offsetlo_reg <= '0;
        end else begin
            opcode_reg   <= instruction[30:25];
            dst_reg      <= instruction[24:20];
            src1_reg     <= src1_next;
            src2_reg     <= src2_next;
            offsetlo_reg <= instruction[9:0];
        end
    end

    assign opcode   = opcode_reg;
    assign dst      = dst_reg;
    assign src1     = src1_reg;
    assign src2     = src2_reg;
    assign offsetlo = offsetlo_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage.
// It applies a table of directed vectors, then runs hand-written reset sequences.
// Expected values are written out by hand for each vector.
// Collision vectors depend on whether DECODE_WB_BYPASS_EN is defined.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [5:0]  opcode;
    logic [4:0]  dst;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [9:0]  offsetlo;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .opcode      (opcode),
        .dst         (dst),
        .src1        (src1),
        .src2        (src2),
        .offsetlo    (offsetlo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [5:0]  e_op;
        logic [4:0]  e_dst;
        logic [31:0] e_s1;
        logic [31:0] e_s2;
        logic [9:0]  e_off;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs [NV];

`ifdef DECODE_WB_BYPASS_EN
    localparam logic [31:0] COLL_R3 = 32'h55AA55AA;
    localparam logic [31:0] COLL_R7 = 32'hCAFEF00D;
`else
    localparam logic [31:0] COLL_R3 = 32'h0;
    localparam logic [31:0] COLL_R7 = 32'h0;
`endif

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] d,
                                       input logic [4:0] s1, input logic [4:0] s2,
                                       input logic [9:0] off);
        return {op, d, s1, s2, off};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".opcode"},   32'(opcode),   32'h0);
        chk({tag, ".dst"},      32'(dst),      32'h0);
        chk({tag, ".src1"},     src1,          32'h0);
        chk({tag, ".src2"},     src2,          32'h0);
        chk({tag, ".offsetlo"}, 32'(offsetlo), 32'h0);
    endtask

    // Drive the inputs on a falling edge, then sample 1 time unit after the next rising edge.
    task automatic step(input logic [31:0] ins, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd);
        @(negedge clk);
        instruction = ins;
        wb_en       = we;
        wb_addr     = wa;
        wb_data     = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Vector table. The register file starts all zero after reset.
        // v0: the opcode field has bit 31 set, so opcode=3F. Write r1. Idx 5 was written during reset, so it must read 0.
        vecs[0]  = '{mk(7'h7F, 5'd7, 5'd5, 5'd9, 10'h3FF), 1'b1, 5'd1, 32'hDEADBEEF,
                     6'h3F, 5'd7, 32'h0, 32'h0, 10'h3FF};
        // v1: read r1 and r2. Write r12.
        vecs[1]  = '{mk(7'h2A, 5'd31, 5'd1, 5'd2, 10'h155), 1'b1, 5'd12, 32'h00001234,
                     6'h2A, 5'd31, 32'hDEADBEEF, 32'h0, 10'h155};
        // v2: field-split instruction from the basic decode case.
        vecs[2]  = '{mk(7'h01, 5'd3, 5'd1, 5'd12, 10'd0), 1'b0, 5'd0, 32'h0,
                     6'h01, 5'd3, 32'hDEADBEEF, 32'h00001234, 10'h000};
        // v3: write to r0 must be dropped. Reading idx 0 returns 0.
        vecs[3]  = '{mk(7'h45, 5'd0, 5'd0, 5'd0, 10'h200), 1'b1, 5'd0, 32'hFFFFFFFF,
                     6'h05, 5'd0, 32'h0, 32'h0, 10'h200};
        // v4: r0 still reads 0 on the edge after the dropped write.
        vecs[4]  = '{mk(7'h10, 5'd4, 5'd0, 5'd12, 10'h001), 1'b0, 5'd0, 32'h0,
                     6'h10, 5'd4, 32'h0, 32'h00001234, 10'h001};
        // v5: same-edge write to r3 while src2 reads idx 3.
        vecs[5]  = '{mk(7'h03, 5'd5, 5'd1, 5'd3, 10'h0AA), 1'b1, 5'd3, 32'h55AA55AA,
                     6'h03, 5'd5, 32'hDEADBEEF, COLL_R3, 10'h0AA};
        // v6: next edge sees r3 in both builds. Both sources use the same index.
        vecs[6]  = '{mk(7'h06, 5'd6, 5'd3, 5'd3, 10'h2AA), 1'b0, 5'd3, 32'h0,
                     6'h06, 5'd6, 32'h55AA55AA, 32'h55AA55AA, 10'h2AA};
        // v7: same-edge write to r7 while both sources read idx 7.
        vecs[7]  = '{mk(7'h3C, 5'd8, 5'd7, 5'd7, 10'h111), 1'b1, 5'd7, 32'hCAFEF00D,
                     6'h3C, 5'd8, COLL_R7, COLL_R7, 10'h111};
        // v8: r7 is visible now. Write r9.
        vecs[8]  = '{mk(7'h21, 5'd9, 5'd7, 5'd1, 10'h222), 1'b1, 5'd9, 32'h0BADF00D,
                     6'h21, 5'd9, 32'hCAFEF00D, 32'hDEADBEEF, 10'h222};
        // v9: wb_en=0 with an address, so r5 must not change.
        vecs[9]  = '{mk(7'h15, 5'd10, 5'd9, 5'd5, 10'h0F0), 1'b0, 5'd5, 32'h11111111,
                     6'h15, 5'd10, 32'h0BADF00D, 32'h0, 10'h0F0};
        // v10: confirm r5 stayed 0 on the following edge.
        vecs[10] = '{mk(7'h00, 5'd11, 5'd5, 5'd9, 10'h30F), 1'b0, 5'd0, 32'h0,
                     6'h00, 5'd11, 32'h0, 32'h0BADF00D, 10'h30F};

        // Reset held while the clock runs and random inputs toggle. Writes are attempted.
        rst_n       = 1'b0;
        instruction = $urandom;
        wb_en       = 1'b1;
        wb_addr     = 5'd5;
        wb_data     = $urandom;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            instruction = $urandom;
            wb_data     = $urandom | 32'h1;
            @(posedge clk);
            #1;
            chk_all_zero("reset_hold");
            $display("reset cycle %0d: op=%h dst=%0d src1=%h src2=%h off=%h",
                     c, opcode, dst, src1, src2, offsetlo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        wb_en = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < NV; i++) begin
            step(vecs[i].instr, vecs[i].wen, vecs[i].waddr, vecs[i].wdata);
            chk($sformatf("v%0d.opcode", i),   32'(opcode),   32'(vecs[i].e_op));
            chk($sformatf("v%0d.dst", i),      32'(dst),      32'(vecs[i].e_dst));
            chk($sformatf("v%0d.src1", i),     src1,          vecs[i].e_s1);
            chk($sformatf("v%0d.src2", i),     src2,          vecs[i].e_s2);
            chk($sformatf("v%0d.offsetlo", i), 32'(offsetlo), 32'(vecs[i].e_off));
            $display("vec %0d: instr=%h wb=%0b/%0d/%h -> op=%h dst=%0d src1=%h src2=%h off=%h",
                     i, vecs[i].instr, vecs[i].wen, vecs[i].waddr, vecs[i].wdata,
                     opcode, dst, src1, src2, offsetlo);
        end

        // Async reset mid-cycle. First load nonzero outputs, then assert reset between edges.
        step(mk(7'h7E, 5'd13, 5'd1, 5'd7, 10'h3AB), 1'b0, 5'd0, 32'h0);
        chk("pre_async.src1", src1, 32'hDEADBEEF);
        chk("pre_async.src2", src2, 32'hCAFEF00D);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        $display("async reset: op=%h dst=%0d src1=%h src2=%h off=%h",
                 opcode, dst, src1, src2, offsetlo);
        @(negedge clk);
        rst_n = 1'b1;

        // After release, every previously written register must read back 0.
        step(mk(7'h01, 5'd1, 5'd1, 5'd12, 10'h000), 1'b0, 5'd0, 32'h0);
        chk("post_rst.r1",  src1, 32'h0);
        chk("post_rst.r12", src2, 32'h0);
        chk("post_rst.opcode", 32'(opcode), 32'h01);
        $display("post reset read r1/r12: src1=%h src2=%h", src1, src2);
        step(mk(7'h01, 5'd2, 5'd3, 5'd7, 10'h000), 1'b0, 5'd0, 32'h0);
        chk("post_rst.r3", src1, 32'h0);
        chk("post_rst.r7", src2, 32'h0);
        $display("post reset read r3/r7: src1=%h src2=%h", src1, src2);
        step(mk(7'h01, 5'd2, 5'd9, 5'd9, 10'h000), 1'b0, 5'd0, 32'h0);
        chk("post_rst.r9a", src1, 32'h0);
        chk("post_rst.r9b", src2, 32'h0);
        $display("post reset read r9/r9: src1=%h src2=%h", src1, src2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
